pipelined_risc_v_core: RTL and testbench

Parametrised successor of the single-issue pipelined CPU. It is a 4-stage in-order RV32I-subset core: IF, ID, EX, WB.
- Adds a valid/ready instruction-fetch handshake, branch resolution with flush, and two-level bypassing (WB→EX, WB→ID write-through).
- Adds ECALL halt and configurable data width, register count and PC width.
- Sits at the top level, driving the program memory and exposing write-back results as the observable output.

---
 rtl/pipelined_risc_v_core.sv | 258 +++++++++++++++++++++++++
 tb/tb_pipelined_risc_v_core.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_risc_v_core.sv
// 4-stage (IF/ID/EX/WB) in-order RV32I-subset core with WB->EX and WB->ID bypassing.
// Ports: clk, rst (async active-low); imem_addr/imem_valid/imem_ready/imem_data fetch handshake;
//   out/wb_valid/wb_reg write-back view; halted after ECALL.
// Optional macro PIPE_PERF_CNT_EN adds retired_cnt and stall_cnt outputs.
module pipelined_risc_v_core #(
   parameter int WIDTH = 32,
   parameter int REG_DEPTH = 32,
   parameter int PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   output logic [PC_WIDTH-1:0] imem_addr,
   output logic                imem_valid,
   input  logic                imem_ready,
   input  logic [31:0]         imem_data,
   output logic [WIDTH-1:0]    out,
   output logic                wb_valid,
   output logic [4:0]          wb_reg,
   output logic                halted
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0]         retired_cnt,
   output logic [31:0]         stall_cnt
`endif
);

   localparam int SHW = $clog2(WIDTH);
   localparam int RIW = $clog2(REG_DEPTH);
   localparam logic [5:0] RD6 = 6'(REG_DEPTH);

   typedef enum logic [3:0] {
      A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU,
      A_XOR, A_SRL, A_SRA, A_OR, A_AND
   } alu_t;

   typedef struct packed {
      logic                v;
      logic [PC_WIDTH-1:0] pc;
      logic [31:0]         ins;
   } if_id_t;

   typedef struct packed {
      logic                v;
      logic                we;
      logic                br;
      logic                bne;
      logic                ecall;
      logic                use_imm;
      alu_t                op;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [WIDTH-1:0]    a;
      logic [WIDTH-1:0]    b;
      logic [WIDTH-1:0]    imm;
      logic [PC_WIDTH-1:0] pc;
   } id_ex_t;

   logic [PC_WIDTH-1:0] pc;
   if_id_t              if_id;
   id_ex_t              id_ex, dec;
   logic [WIDTH-1:0]    rf [REG_DEPTH];

   logic xfer, take, ecall_ex, kill, wb_wr;
   logic [PC_WIDTH-1:0] target;
   logic [WIDTH-1:0]    a_ex, b_ex, opb, res;

   function automatic logic reg_ok(input logic [4:0] i);
      return (i != 5'd0) && ({1'b0, i} < RD6);
   endfunction

   // ID read with write-through of the instruction retiring this cycle
   function automatic logic [WIDTH-1:0] rd_reg(input logic [4:0] i);
      if (!reg_ok(i))
         return '0;
      else if (wb_wr && wb_reg == i)
         return out;
      else
         return rf[i[RIW-1:0]];
   endfunction

   function automatic alu_t alu_sel(input logic [2:0] f3, input logic alt);
      alu_t r;
      unique case (f3)
         3'd0: r = alt ? A_SUB : A_ADD;
         3'd1: r = A_SLL;
         3'd2: r = A_SLT;
         3'd3: r = A_SLTU;
         3'd4: r = A_XOR;
         3'd5: r = alt ? A_SRA : A_SRL;
         3'd6: r = A_OR;
         default: r = A_AND;
      endcase
      return r;
   endfunction

   assign imem_valid = rst && !halted;
   assign imem_addr  = pc;
   assign xfer       = imem_valid && imem_ready;
   assign wb_wr      = wb_valid && reg_ok(wb_reg);

   // ---------------- ID: decode ----------------
   logic [31:0] ins;
   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic        is_op, is_opi, is_lui, is_br, is_ecall;
   logic        op_ok, opi_ok, sh_ok;
   logic [WIDTH-1:0] imm_i, imm_u, imm_b;
   logic signed [31:0] u32;
   logic signed [12:0] b13;

   assign ins = if_id.ins;
   assign opc = ins[6:0];
   assign f3  = ins[14:12];
   assign f7  = ins[31:25];
   assign u32 = {ins[31:12], 12'b0};
   assign b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_i = WIDTH'($signed(ins[31:20]));
   assign imm_u = WIDTH'(u32);
   assign imm_b = WIDTH'(b13);

   assign is_ecall = ins == 32'h0000_0073;
   assign is_op    = opc == 7'h33;
   assign is_opi   = opc == 7'h13;
   assign is_lui   = opc == 7'h37;
   assign is_br    = opc == 7'h63;

   assign op_ok = (f7 == 7'h00) ||
                  (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
   // RV32 requires shamt[5]=0; RV64 uses it as a shift bit
   assign sh_ok = (WIDTH == 64) || !ins[25];
   always_comb begin
      opi_ok = 1'b1;
      if (f3 == 3'd1)
         opi_ok = ins[31:26] == 6'd0 && sh_ok;
      else if (f3 == 3'd5)
         opi_ok = (ins[31:26] == 6'd0 || ins[31:26] == 6'b010000) && sh_ok;
   end

   always_comb begin
      dec     = '0;
      dec.v   = if_id.v;
      dec.pc  = if_id.pc;
      dec.rd  = ins[11:7];
      dec.rs1 = ins[19:15];
      dec.rs2 = ins[24:20];
      dec.imm = imm_i;
      unique case (1'b1)
         is_op: begin
            dec.we = op_ok;
            dec.op = alu_sel(f3, ins[30]);
         end
         is_opi: begin
            dec.we      = opi_ok;
            dec.op      = alu_sel(f3, ins[30] && f3 == 3'd5);
            dec.use_imm = 1'b1;
            dec.rs2     = 5'd0;
         end
         is_lui: begin
            dec.we      = 1'b1;
            dec.use_imm = 1'b1;
            dec.imm     = imm_u;
            dec.rs1     = 5'd0;
            dec.rs2     = 5'd0;
            dec.op      = A_ADD;
         end
         is_br: begin
            dec.br  = f3[2:1] == 2'b00;
            dec.bne = f3[0];
            dec.imm = imm_b;
         end
         is_ecall: dec.ecall = 1'b1;
         default: ;
      endcase
      dec.a = rd_reg(dec.rs1);
      dec.b = rd_reg(dec.rs2);
   end

   // ---------------- EX ----------------
   assign a_ex = (wb_wr && wb_reg == id_ex.rs1) ? out : id_ex.a;
   assign b_ex = (wb_wr && wb_reg == id_ex.rs2) ? out : id_ex.b;
   assign opb  = id_ex.use_imm ? id_ex.imm : b_ex;

   always_comb begin
      res = '0;
      unique case (id_ex.op)
         A_ADD:  res = a_ex + opb;
         A_SUB:  res = a_ex - opb;
         A_SLL:  res = a_ex << opb[SHW-1:0];
         A_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a_ex) < $signed(opb)};
         A_SLTU: res = {{(WIDTH-1){1'b0}}, a_ex < opb};
         A_XOR:  res = a_ex ^ opb;
         A_SRL:  res = a_ex >> opb[SHW-1:0];
         A_SRA:  res = $unsigned($signed(a_ex) >>> opb[SHW-1:0]);
         A_OR:   res = a_ex | opb;
         default: res = a_ex & opb;
      endcase
   end

   assign take     = id_ex.v && id_ex.br && ((a_ex == b_ex) ^ id_ex.bne);
   assign ecall_ex = id_ex.v && id_ex.ecall;
   assign kill     = take || ecall_ex;
   assign target   = id_ex.pc + PC_WIDTH'($signed(id_ex.imm));

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= RESET_PC;
         if_id    <= '0;
         id_ex    <= '0;
         wb_valid <= 1'b0;
         wb_reg   <= 5'd0;
         out      <= '0;
         halted   <= 1'b0;
      end else begin
         if (take)
            pc <= target;
         else if (xfer && !ecall_ex)
            pc <= pc + PC_WIDTH'(4);
         if_id.v   <= xfer && !kill;
         if_id.pc  <= pc;
         if_id.ins <= imem_data;
         id_ex     <= kill ? '0 : dec;
         wb_valid  <= id_ex.v && id_ex.we;
         if (id_ex.v && id_ex.we) begin
            wb_reg <= id_ex.rd;
            out    <= res;
         end
         if (ecall_ex)
            halted <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_DEPTH; i++)
            rf[i] <= '0;
      end else if (wb_wr) begin
         rf[wb_reg[RIW-1:0]] <= out;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retired_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if (wb_valid)
            retired_cnt <= retired_cnt + 32'd1;
         if (imem_valid && !imem_ready)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipelined_risc_v_core.sv
// Directed bench for pipelined_risc_v_core: bypass, branch flush, fetch stall, x0 write, ECALL halt, async reset.
module tb_pipelined_risc_v_core;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  imem_addr;
   logic        imem_valid, imem_ready;
   logic [31:0] imem_data;
   logic [31:0] out;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic        halted;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] retired_cnt, stall_cnt;
`endif

   pipelined_risc_v_core dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_valid(imem_valid),
      .imem_ready(imem_ready), .imem_data(imem_data),
      .out(out), .wb_valid(wb_valid), .wb_reg(wb_reg),
      .halted(halted)
`ifdef PIPE_PERF_CNT_EN
      , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] mem [64];
   assign imem_data = mem[imem_addr[7:2]];

   int cyc;
   bit stall_run = 1'b0;
   int run = 0;
   assign imem_ready = !(stall_run && cyc >= 2 && cyc <= 4);

   always @(posedge clk or negedge rst)
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;

   logic [7:0]  addr_log [2][64];
   bit          vld_log  [2][64];
   logic [4:0]  ev_reg   [2][32];
   logic [31:0] ev_val   [2][32];
   int          ev_cyc   [2][32];
   int          n_ev     [2] = '{0, 0};

   always @(negedge clk) begin
      if (rst) begin
         if (cyc < 64) begin
            addr_log[run][cyc] = imem_addr;
            vld_log[run][cyc]  = imem_valid;
         end
         if (wb_valid && n_ev[run] < 32) begin
            ev_reg[run][n_ev[run]] = wb_reg;
            ev_val[run][n_ev[run]] = out;
            ev_cyc[run][n_ev[run]] = cyc;
            n_ev[run] = n_ev[run] + 1;
         end
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] ei(input int imm, input int rs1,
                                      input int f3, input int rd,
                                      input logic [6:0] op);
      logic [11:0] im;
      im = imm[11:0];
      return {im, 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction

   function automatic logic [31:0] er(input int f7, input int rs2,
                                      input int rs1, input int f3,
                                      input int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction

   function automatic logic [31:0] eb(input int imm, input int rs2,
                                      input int rs1, input int f3);
      logic [12:0] b;
      b = imm[12:0];
      return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'(f3),
              b[4:1], b[11], 7'h63};
   endfunction

   logic [4:0]  exp_reg [11] = '{1, 2, 3, 4, 8, 5, 6, 0, 9, 10, 1};
   logic [31:0] exp_val [11] = '{32'd5, 32'd8, 32'd3, 32'd1, 32'd7,
                                 32'h8000_0000, 32'hF800_0000, 32'd9,
                                 32'd0, 32'hFFFF_FFF7, 32'd2};

   task automatic check_reset(input string p);
      check({p, "_addr"}, imem_addr, 0);
      check({p, "_ivalid"}, imem_valid, 0);
      check({p, "_out"}, out, 0);
      check({p, "_wbv"}, wb_valid, 0);
      check({p, "_wbreg"}, wb_reg, 0);
      check({p, "_halted"}, halted, 0);
   endtask

   task automatic run_to_halt(input int r);
      for (int i = 0; i < 80 && !halted; i++) @(negedge clk);
      check($sformatf("r%0d_halted", r), halted, 1);
      repeat (3) @(negedge clk);
      check($sformatf("r%0d_ivalid_halt", r), imem_valid, 0);
      check($sformatf("r%0d_nev", r), n_ev[r], 11);
      for (int k = 0; k < 11; k++) begin
         check($sformatf("r%0d_reg%0d", r, k), ev_reg[r][k], exp_reg[k]);
         check($sformatf("r%0d_val%0d", r, k), ev_val[r][k], exp_val[k]);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0]  = ei(5, 0, 0, 1, 7'h13);
      mem[1]  = ei(3, 1, 0, 2, 7'h13);
      mem[2]  = er(32, 1, 2, 0, 3);
      mem[3]  = er(0, 2, 1, 2, 4);
      mem[4]  = eb(8, 1, 1, 0);
      mem[5]  = ei(1, 0, 0, 7, 7'h13);
      mem[6]  = ei(7, 0, 0, 8, 7'h13);
      mem[7]  = {20'h80000, 5'd5, 7'h37};
      mem[8]  = ei('h404, 5, 5, 6, 7'h13);
      mem[9]  = ei(9, 0, 0, 0, 7'h13);
      mem[10] = er(0, 0, 0, 0, 9);
      mem[11] = eb(8, 1, 1, 1);
      mem[12] = ei(-1, 2, 4, 10, 7'h13);
      mem[13] = ei(2, 0, 0, 1, 7'h13);
      mem[14] = 32'h0000_0073;
      mem[15] = ei(1, 0, 0, 11, 7'h13);

      #12;
      check_reset("rst0");

      @(negedge clk) rst = 1'b1;
      run_to_halt(0);
      check("r0_lat0", ev_cyc[0][0], 3);
      check("r0_lat1", ev_cyc[0][1], 4);
      check("r0_br_addr", addr_log[0][7], 8'h18);
      check("r0_x8_cyc", ev_cyc[0][4], 10);
      check("r0_last_cyc", ev_cyc[0][10], 17);
`ifdef PIPE_PERF_CNT_EN
      check("r0_stall_cnt", stall_cnt, 0);
      check("r0_retired_cnt", retired_cnt, 11);
`endif

      #2 rst = 1'b0;
      #1 check_reset("rst_mid");

      run = 1;
      stall_run = 1'b1;
      @(negedge clk) rst = 1'b1;
      run_to_halt(1);
      for (int k = 2; k <= 4; k++)
         check($sformatf("r1_hold_addr%0d", k), addr_log[1][k], 8'h08);
      check("r1_stall_ivalid", vld_log[1][3], 1);
      check("r1_br_addr", addr_log[1][10], 8'h18);
      check("r1_lat1", ev_cyc[1][1], 4);
      check("r1_last_cyc", ev_cyc[1][10], 20);
`ifdef PIPE_PERF_CNT_EN
      check("r1_stall_cnt", stall_cnt, 3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
